// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive front-end.
// Takes the asynchronous serial line, samples each bit PRESCALE times and
// takes a 2-of-3 vote around the bit centre. Optional parity and the stop
// bit are checked, and each frame ends in exactly one one-cycle result
// strobe (DATA_VALID, PAR_ERR or STP_ERR).
module uart_rx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  UART_CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESC_W-1:0]    PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, rxS_q;
    logic [PRESC_W-1:0]    edgeCnt_q, edgeCnt_d;
    logic [BIT_W-1:0]      bitCnt_q, bitCnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  s0_q, s0_d, s1_q, s1_d;
    logic                  bitVal_q, bitVal_d;
    logic                  parMis_q, parMis_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic                  parEn_q, parEn_d;
    logic                  parTyp_q, parTyp_d;
    logic [DATA_WIDTH-1:0] pData_q, pData_d;
    logic                  dataValid_q, dataValid_d;
    logic                  parErr_q, parErr_d;
    logic                  stpErr_q, stpErr_d;

    logic [PRESC_W-1:0]    half;
    logic                  lastTick;
    logic                  midTick;
    logic                  maj;

    assign half     = {1'b0, presc_q[PRESC_W-1:1]};
    assign lastTick = (edgeCnt_q == presc_q - PRESC_W'(1));
    assign midTick  = (edgeCnt_q == half + PRESC_W'(1));
    assign maj      = (s0_q & s1_q) | (s0_q & rxS_q) | (s1_q & rxS_q);

    assign P_DATA     = pData_q;
    assign DATA_VALID = dataValid_q;
    assign PAR_ERR    = parErr_q;
    assign STP_ERR    = stpErr_q;

    // Two-flop synchronizer bringing the asynchronous line into UART_CLK; idles high.
    always_ff @(posedge UART_CLK) begin
        if (RST) begin
            sync1_q <= 1'b1;
            rxS_q   <= 1'b1;
        end else begin
            sync1_q <= RX_IN;
            rxS_q   <= sync1_q;
        end
    end

    // State, counters, sample history, latched frame configuration and result strobes.
    always_ff @(posedge UART_CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            edgeCnt_q   <= '0;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            s0_q        <= 1'b1;
            s1_q        <= 1'b1;
            bitVal_q    <= 1'b1;
            parMis_q    <= 1'b0;
            presc_q     <= '0;
            parEn_q     <= 1'b0;
            parTyp_q    <= 1'b0;
            pData_q     <= '0;
            dataValid_q <= 1'b0;
            parErr_q    <= 1'b0;
            stpErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            edgeCnt_q   <= edgeCnt_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            bitVal_q    <= bitVal_d;
            parMis_q    <= parMis_d;
            presc_q     <= presc_d;
            parEn_q     <= parEn_d;
            parTyp_q    <= parTyp_d;
            pData_q     <= pData_d;
            dataValid_q <= dataValid_d;
            parErr_q    <= parErr_d;
            stpErr_q    <= stpErr_d;
        end
    end

    // Frame sequencing: oversample timing, majority vote, shifting, checks and the final strobe.
    always_comb begin
        state_d     = state_q;
        edgeCnt_d   = edgeCnt_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        bitVal_d    = bitVal_q;
        parMis_d    = parMis_q;
        presc_d     = presc_q;
        parEn_d     = parEn_q;
        parTyp_d    = parTyp_q;
        pData_d     = pData_q;
        dataValid_d = 1'b0;
        parErr_d    = 1'b0;
        stpErr_d    = 1'b0;

        if (state_q != IDLE) begin
            edgeCnt_d = lastTick ? '0 : edgeCnt_q + PRESC_W'(1);
            if (edgeCnt_q == half - PRESC_W'(1)) s0_d = rxS_q;
            if (edgeCnt_q == half)               s1_d = rxS_q;
            if (midTick)                         bitVal_d = maj;
        end

        case (state_q)
            IDLE: begin
                edgeCnt_d = '0;
                if (!rxS_q) begin
                    state_d   = START;
                    edgeCnt_d = PRESC_W'(1);
                    bitCnt_d  = '0;
                    parMis_d  = 1'b0;
                    presc_d   = PRESCALE;
                    parEn_d   = PAR_EN;
                    parTyp_d  = PAR_TYP;
                end
            end
            START: begin
                if (midTick && maj) begin
                    state_d   = IDLE;
                    edgeCnt_d = '0;
                end else if (lastTick) begin
                    state_d  = DATA;
                    bitCnt_d = '0;
                end
            end
            DATA: begin
                if (midTick) shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
                if (lastTick) begin
                    if (bitCnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        bitCnt_d = '0;
                        state_d  = parEn_q ? PARITY : STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (midTick) parMis_d = (maj != ((^shift_q) ^ parTyp_q));
                if (lastTick) state_d = STOP;
            end
            STOP: begin
                if (lastTick) begin
                    state_d = IDLE;
                    if (!bitVal_q) begin
                        stpErr_d = 1'b1;
                    end else if (parMis_q) begin
                        parErr_d = 1'b1;
                    end else begin
                        dataValid_d = 1'b1;
                        pData_d     = shift_q;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                edgeCnt_d = '0;
            end
        endcase
    end

endmodule
